// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin arbiter for four requesters sharing one peripheral.
// Three-state FSM (IDLE/SEND/RELEASE) with ack timeout and transfer counter.
module bus_arbiter #(
  parameter int TIMEOUT = 15
) (
  input  logic        arb_clock,
  input  logic        arb_reset,
  input  logic [3:0]  req_send,
  input  logic [15:0] req_dados,
  output logic [3:0]  req_ack,
  output logic        per_send,
  output logic [3:0]  per_dados,
  input  logic        per_ack,
  output logic [1:0]  grant_id,
  output logic        busy,
  output logic        timeout_err,
  output logic [7:0]  xfer_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND    = 2'd1,
    RELEASE = 2'd2
  } state_t;

  localparam logic [3:0] LAST_CNT = 4'(TIMEOUT - 1);

  state_t     state, state_n;
  logic [1:0] last_grant, last_grant_n;
  logic [3:0] wait_cnt, wait_cnt_n;
  logic [3:0] req_ack_n;
  logic       per_send_n;
  logic [3:0] per_dados_n;
  logic [1:0] grant_id_n;
  logic       busy_n;
  logic       timeout_err_n;
  logic [7:0] xfer_count_n;

  logic       found;
  logic [1:0] sel;
  logic [1:0] idx;

  // Search starts just after the last grant, so it gets lowest priority.
  always_comb begin
    found = 1'b0;
    sel   = 2'd0;
    idx   = 2'd0;
    for (int i = 1; i <= 4; i++) begin
      idx = last_grant + i[1:0];
      if (!found && req_send[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end

  always_comb begin
    state_n       = state;
    last_grant_n  = last_grant;
    wait_cnt_n    = wait_cnt;
    req_ack_n     = req_ack;
    per_send_n    = per_send;
    per_dados_n   = per_dados;
    grant_id_n    = grant_id;
    timeout_err_n = 1'b0;
    xfer_count_n  = xfer_count;
    unique case (state)
      IDLE: begin
        req_ack_n  = 4'd0;
        per_send_n = 1'b0;
        if (found) begin
          grant_id_n  = sel;
          per_dados_n = req_dados[{sel, 2'b00} +: 4];
          per_send_n  = 1'b1;
          wait_cnt_n  = 4'd0;
          state_n     = SEND;
        end
      end
      SEND: begin
        if (per_ack) begin
          per_send_n = 1'b0;
          req_ack_n  = 4'b0001 << grant_id;
          state_n    = RELEASE;
        end else if (wait_cnt == LAST_CNT) begin
          per_send_n    = 1'b0;
          timeout_err_n = 1'b1;
          last_grant_n  = grant_id;
          state_n       = IDLE;
        end else begin
          wait_cnt_n = wait_cnt + 4'd1;
        end
      end
      RELEASE: begin
        if (!req_send[grant_id] && !per_ack) begin
          req_ack_n    = 4'd0;
          last_grant_n = grant_id;
          xfer_count_n = xfer_count + 8'd1;
          state_n      = IDLE;
        end
      end
      default: begin
        req_ack_n  = 4'd0;
        per_send_n = 1'b0;
        state_n    = IDLE;
      end
    endcase
    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge arb_clock) begin
    if (arb_reset) begin
      state       <= IDLE;
      last_grant  <= 2'd3;
      wait_cnt    <= 4'd0;
      req_ack     <= 4'd0;
      per_send    <= 1'b0;
      per_dados   <= 4'd0;
      grant_id    <= 2'd0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
      xfer_count  <= 8'd0;
    end else begin
      state       <= state_n;
      last_grant  <= last_grant_n;
      wait_cnt    <= wait_cnt_n;
      req_ack     <= req_ack_n;
      per_send    <= per_send_n;
      per_dados   <= per_dados_n;
      grant_id    <= grant_id_n;
      busy        <= busy_n;
      timeout_err <= timeout_err_n;
      xfer_count  <= xfer_count_n;
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed self-checking bench for bus_arbiter.
// Linear stimulus with immediate assertions at each check point.
module tb_bus_arbiter;

  logic        arb_clock = 1'b0;
  logic        arb_reset = 1'b0;
  logic [3:0]  req_send  = 4'd0;
  logic [15:0] req_dados = 16'd0;
  logic [3:0]  req_ack;
  logic        per_send;
  logic [3:0]  per_dados;
  logic        per_ack   = 1'b0;
  logic [1:0]  grant_id;
  logic        busy;
  logic        timeout_err;
  logic [7:0]  xfer_count;

  int n_assert = 0;
  int n_fail   = 0;
  int cnt;
  logic [1:0] g;

  bus_arbiter #(.TIMEOUT(15)) dut (
    .arb_clock   (arb_clock),
    .arb_reset   (arb_reset),
    .req_send    (req_send),
    .req_dados   (req_dados),
    .req_ack     (req_ack),
    .per_send    (per_send),
    .per_dados   (per_dados),
    .per_ack     (per_ack),
    .grant_id    (grant_id),
    .busy        (busy),
    .timeout_err (timeout_err),
    .xfer_count  (xfer_count)
  );

  always #5 arb_clock = ~arb_clock;

  task automatic tick();
    @(posedge arb_clock);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    req_send  = 4'd0;
    req_dados = 16'd0;
    per_ack   = 1'b0;
    arb_reset = 1'b1;
    tick();
    tick();
    arb_reset = 1'b0;
  endtask

  task automatic all_zero(input string tag);
    chk({tag, "_ack"}, 32'(req_ack), 32'h0);
    chk({tag, "_psend"}, 32'(per_send), 32'h0);
    chk({tag, "_pdados"}, 32'(per_dados), 32'h0);
    chk({tag, "_gid"}, 32'(grant_id), 32'h0);
    chk({tag, "_busy"}, 32'(busy), 32'h0);
    chk({tag, "_terr"}, 32'(timeout_err), 32'h0);
    chk({tag, "_cnt"}, 32'(xfer_count), 32'h0);
  endtask

  // Quick transfer for requester 0 with immediate ack and release.
  task automatic quick_xfer();
    req_send = 4'b0001;
    tick();
    per_ack = 1'b1;
    tick();
    per_ack  = 1'b0;
    req_send = 4'b0000;
    tick();
  endtask

  initial begin
    do_reset();
    all_zero("reset");

    req_send  = 4'b0100;
    req_dados = 16'h0A00;
    tick();
    chk("r35_psend", 32'(per_send), 32'h1);
    chk("r35_pdados", 32'(per_dados), 32'hA);
    chk("r35_gid", 32'(grant_id), 32'h2);
    chk("r35_busy", 32'(busy), 32'h1);
    tick();
    tick();
    chk("r35_hold", 32'(per_send), 32'h1);
    per_ack = 1'b1;
    tick();
    chk("r35_ack", 32'(req_ack), 32'h4);
    chk("r35_psend0", 32'(per_send), 32'h0);
    per_ack  = 1'b0;
    tick();
    chk("r35_stay", 32'(req_ack), 32'h4);
    req_send = 4'b0000;
    tick();
    chk("r35_rel", 32'(req_ack), 32'h0);
    chk("r35_busy0", 32'(busy), 32'h0);
    chk("r35_cnt", 32'(xfer_count), 32'h1);

    do_reset();
    req_send  = 4'b1111;
    req_dados = 16'h4321;
    for (int k = 0; k < 5; k++) begin
      tick();
      g = 2'(k % 4);
      chk("r36_gid", 32'(grant_id), 32'(g));
      chk("r36_data", 32'(per_dados), 32'(k % 4 + 1));
      per_ack = 1'b1;
      tick();
      chk("r36_ack", 32'(req_ack), 32'(4'b0001 << g));
      chk("r36_onehot", 32'($countones(req_ack)), 32'h1);
      per_ack  = 1'b0;
      req_send = 4'b1111 & ~(4'b0001 << g);
      tick();
      chk("r36_rel", 32'(req_ack), 32'h0);
      req_send = 4'b1111;
    end
    chk("r36_cnt", 32'(xfer_count), 32'h5);

    do_reset();
    req_send  = 4'b0010;
    req_dados = 16'h0070;
    tick();
    cnt = per_send ? 1 : 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (per_send) cnt++;
      else break;
    end
    chk("r37_len", 32'(cnt), 32'd15);
    chk("r37_terr", 32'(timeout_err), 32'h1);
    chk("r37_ack", 32'(req_ack), 32'h0);
    chk("r37_cnt", 32'(xfer_count), 32'h0);
    chk("r37_busy", 32'(busy), 32'h0);
    req_send = 4'b0110;
    tick();
    chk("r37_pulse", 32'(timeout_err), 32'h0);
    chk("r30_gid", 32'(grant_id), 32'h2);
    for (int k = 0; k < 14; k++) tick();
    chk("r23_pre", 32'(per_send), 32'h1);
    per_ack = 1'b1;
    tick();
    chk("r23_ack", 32'(req_ack), 32'h4);
    chk("r23_terr", 32'(timeout_err), 32'h0);
    per_ack  = 1'b0;
    req_send = 4'b0000;
    tick();
    chk("r23_cnt", 32'(xfer_count), 32'h1);

    req_send  = 4'b0010;
    req_dados = 16'h0030;
    tick();
    chk("r38_gid", 32'(grant_id), 32'h1);
    chk("r38_d0", 32'(per_dados), 32'h3);
    req_dados = 16'h00C0;
    tick();
    chk("r38_d1", 32'(per_dados), 32'h3);
    req_send = 4'b0000;
    tick();
    chk("r38_d2", 32'(per_dados), 32'h3);
    chk("r26_psend", 32'(per_send), 32'h1);
    per_ack = 1'b1;
    tick();
    chk("r38_ack", 32'(req_ack), 32'h2);
    chk("r38_d3", 32'(per_dados), 32'h3);
    per_ack = 1'b0;
    tick();
    chk("r38_cnt", 32'(xfer_count), 32'h2);

    req_send  = 4'b0001;
    req_dados = 16'h5005;
    tick();
    per_ack = 1'b1;
    tick();
    chk("r39_ack", 32'(req_ack), 32'h1);
    per_ack   = 1'b0;
    arb_reset = 1'b1;
    tick();
    all_zero("r39");
    arb_reset = 1'b0;
    req_send  = 4'b1001;
    tick();
    chk("r39_gid", 32'(grant_id), 32'h0);
    chk("r39_data", 32'(per_dados), 32'h5);

    do_reset();
    for (int k = 0; k < 255; k++) quick_xfer();
    chk("r40_255", 32'(xfer_count), 32'd255);
    quick_xfer();
    chk("r40_wrap", 32'(xfer_count), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
